// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (inhibit, request, bit shifting, ack).
// Optional: define PS2_TX_ACK_CHECK_EN to turn a high ack level into tx_err.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       kb_clk_in,
  input  logic       kb_data_in,
  output logic       kb_clk_oe,
  output logic       kb_data_oe,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int MAX_CYC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INHIBIT = 3'd1,
    REQ     = 3'd2,
    SHIFT   = 3'd3,
    ACK     = 3'd4
  } state_t;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [3:0]       bit_idx_r;
  logic [7:0]       shift_r;
  logic             parity_r;
  logic [1:0]       clk_sync_r;
  logic [1:0]       data_sync_r;
  logic             clk_prev_r;
  logic             kb_clk_oe_r;
  logic             kb_data_oe_r;
  logic             tx_ready_r;
  logic             tx_done_r;
  logic             tx_err_r;
  logic             fall_s;
  logic             ack_ok_s;

  // Two-flop synchronizers for the pin levels plus the previous synced clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_r  <= 2'b11;
      data_sync_r <= 2'b11;
      clk_prev_r  <= 1'b1;
    end else begin
      clk_sync_r  <= {clk_sync_r[0], kb_clk_in};
      data_sync_r <= {data_sync_r[0], kb_data_in};
      clk_prev_r  <= clk_sync_r[1];
    end
  end

  assign fall_s = clk_prev_r & ~clk_sync_r[1];

`ifdef PS2_TX_ACK_CHECK_EN
  assign ack_ok_s = ~data_sync_r[1];
`else
  // The ack level is a don't-care in this build; any eleventh edge completes.
  assign ack_ok_s = data_sync_r[1] | 1'b1;
`endif

  // Transfer sequencer; all line drives and status flags are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_r        <= '0;
      bit_idx_r    <= 4'd0;
      shift_r      <= 8'd0;
      parity_r     <= 1'b0;
      kb_clk_oe_r  <= 1'b0;
      kb_data_oe_r <= 1'b0;
      tx_ready_r   <= 1'b1;
      tx_done_r    <= 1'b0;
      tx_err_r     <= 1'b0;
    end else begin
      tx_done_r <= 1'b0;
      tx_err_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          kb_clk_oe_r  <= 1'b0;
          kb_data_oe_r <= 1'b0;
          if (tx_valid) begin
            shift_r     <= tx_data;
            parity_r    <= odd_parity(tx_data);
            cnt_r       <= '0;
            tx_ready_r  <= 1'b0;
            kb_clk_oe_r <= 1'b1;
            state_r     <= INHIBIT;
          end else begin
            tx_ready_r <= 1'b1;
          end
        end
        INHIBIT: begin
          if (cnt_r == INH_LAST) begin
            cnt_r        <= '0;
            kb_data_oe_r <= 1'b1;
            state_r      <= REQ;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        REQ: begin
          kb_clk_oe_r <= 1'b0;
          bit_idx_r   <= 4'd0;
          cnt_r       <= '0;
          state_r     <= SHIFT;
        end
        SHIFT, ACK: begin
          if (cnt_r == TO_LAST) begin
            kb_clk_oe_r  <= 1'b0;
            kb_data_oe_r <= 1'b0;
            tx_err_r     <= 1'b1;
            tx_ready_r   <= 1'b1;
            state_r      <= IDLE;
          end else begin
            cnt_r <= cnt_r + 1'b1;
            if (fall_s) begin
              if (state_r == ACK) begin
                tx_done_r  <= ack_ok_s;
                tx_err_r   <= ~ack_ok_s;
                tx_ready_r <= 1'b1;
                state_r    <= IDLE;
              end else begin
                bit_idx_r <= bit_idx_r + 4'd1;
                case (bit_idx_r)
                  4'd0, 4'd1, 4'd2, 4'd3,
                  4'd4, 4'd5, 4'd6, 4'd7: kb_data_oe_r <= ~shift_r[bit_idx_r[2:0]];
                  4'd8:    kb_data_oe_r <= ~parity_r;
                  4'd9: begin
                    kb_data_oe_r <= 1'b0;
                    state_r      <= ACK;
                  end
                  default: kb_data_oe_r <= 1'b0;
                endcase
              end
            end
          end
        end
        default: begin
          kb_clk_oe_r  <= 1'b0;
          kb_data_oe_r <= 1'b0;
          tx_ready_r   <= 1'b1;
          state_r      <= IDLE;
        end
      endcase
    end
  end

  assign kb_clk_oe  = kb_clk_oe_r;
  assign kb_data_oe = kb_data_oe_r;
  assign tx_ready   = tx_ready_r;
  assign tx_done    = tx_done_r;
  assign tx_err     = tx_err_r;

endmodule
